// File: rtl/repetition_ecc_arbiter_if.sv
// Bundle of requester, codec and response signals around repetition_ecc_arbiter.
// slave = arbiter side, master = environment (requesters, codec, response sink).
interface repetition_ecc_arbiter_if #(
   parameter int DATA_WIDTH        = 8,
   parameter int REPETITION_FACTOR = 3,
   parameter int NUM_REQ           = 2
);
   localparam int CW   = DATA_WIDTH * REPETITION_FACTOR;
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ-1:0]      req_op;
   logic [NUM_REQ*CW-1:0]   req_payload;

   logic                    codec_encode_en;
   logic                    codec_decode_en;
   logic [DATA_WIDTH-1:0]   codec_data_in;
   logic [CW-1:0]           codec_codeword_in;
   logic [CW-1:0]           codec_codeword_out;
   logic [DATA_WIDTH-1:0]   codec_data_out;
   logic                    codec_error_corrected;
   logic                    codec_valid_out;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic                    rsp_op;
   logic [CW-1:0]           rsp_data;
   logic                    rsp_corrected;
   logic                    rsp_timeout;

   logic                    busy;
   logic [15:0]             corr_count;

   modport slave (
      input  req_valid, req_op, req_payload,
      output req_ready,
      output codec_encode_en, codec_decode_en, codec_data_in, codec_codeword_in,
      input  codec_codeword_out, codec_data_out, codec_error_corrected, codec_valid_out,
      output rsp_valid, rsp_id, rsp_op, rsp_data, rsp_corrected, rsp_timeout,
      input  rsp_ready,
      output busy, corr_count
   );

   modport master (
      output req_valid, req_op, req_payload,
      input  req_ready,
      input  codec_encode_en, codec_decode_en, codec_data_in, codec_codeword_in,
      output codec_codeword_out, codec_data_out, codec_error_corrected, codec_valid_out,
      input  rsp_valid, rsp_id, rsp_op, rsp_data, rsp_corrected, rsp_timeout,
      output rsp_ready,
      input  busy, corr_count
   );
endinterface

// File: rtl/repetition_ecc_arbiter.sv
// Round-robin sharing of one registered repetition-code codec among NUM_REQ clients.
// Optional corrected-error counter enabled by REPETITION_ECC_ARB_STATS_EN.
module repetition_ecc_arbiter #(
   parameter int DATA_WIDTH        = 8,
   parameter int REPETITION_FACTOR = 3,
   parameter int NUM_REQ           = 2,
   parameter int TIMEOUT           = 15
) (
   input logic                    clk,
   input logic                    rst_n,
   repetition_ecc_arbiter_if.slave bus
);
   localparam int CW    = DATA_WIDTH * REPETITION_FACTOR;
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]         state;
   logic [ID_W-1:0]    last_grant;
   logic [ID_W-1:0]    id_q;
   logic               op_q;
   logic [CW-1:0]      pay_q;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CW-1:0]      rsp_data_q;
   logic               rsp_corr_q;
   logic               rsp_to_q;

   logic               gnt_any;
   logic [ID_W-1:0]    gnt_idx;
   logic [NUM_REQ-1:0] gnt_oh;
   logic               gnt_op;
   logic [CW-1:0]      gnt_pay;

   // Two passes: indices above last_grant first, then wrap to the lowest valid index.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      gnt_op  = 1'b0;
      gnt_pay = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && bus.req_valid[i] && (i > int'(last_grant))) begin
            gnt_any   = 1'b1;
            gnt_idx   = ID_W'(i);
            gnt_oh    = '0;
            gnt_oh[i] = 1'b1;
            gnt_op    = bus.req_op[i];
            gnt_pay   = bus.req_payload[i*CW +: CW];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && bus.req_valid[i]) begin
            gnt_any   = 1'b1;
            gnt_idx   = ID_W'(i);
            gnt_oh    = '0;
            gnt_oh[i] = 1'b1;
            gnt_op    = bus.req_op[i];
            gnt_pay   = bus.req_payload[i*CW +: CW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         id_q       <= '0;
         op_q       <= 1'b0;
         pay_q      <= '0;
         wait_cnt   <= '0;
         rsp_data_q <= '0;
         rsp_corr_q <= 1'b0;
         rsp_to_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  op_q       <= gnt_op;
                  pay_q      <= gnt_pay;
                  id_q       <= gnt_idx;
                  last_grant <= gnt_idx;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // wait_cnt lags the cycles since ISSUE by one, so TIMEOUT-2 lands RESP at ISSUE+TIMEOUT.
               if (bus.codec_valid_out) begin
                  rsp_data_q <= op_q ? CW'(bus.codec_data_out) : bus.codec_codeword_out;
                  rsp_corr_q <= op_q & bus.codec_error_corrected;
                  rsp_to_q   <= 1'b0;
                  state      <= S_RESP;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 2)) begin
                  rsp_data_q <= '0;
                  rsp_corr_q <= 1'b0;
                  rsp_to_q   <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Gated by rst_n so every output reads zero while reset is held.
   assign bus.req_ready         = (rst_n && state == S_IDLE) ? gnt_oh : '0;
   assign bus.codec_encode_en   = (state == S_ISSUE) && !op_q;
   assign bus.codec_decode_en   = (state == S_ISSUE) &&  op_q;
   assign bus.codec_data_in     = pay_q[DATA_WIDTH-1:0];
   assign bus.codec_codeword_in = pay_q;
   assign bus.rsp_valid         = (state == S_RESP);
   assign bus.rsp_id            = id_q;
   assign bus.rsp_op            = op_q;
   assign bus.rsp_data          = rsp_data_q;
   assign bus.rsp_corrected     = rsp_corr_q;
   assign bus.rsp_timeout       = rsp_to_q;
   assign bus.busy              = (state != S_IDLE);

`ifdef REPETITION_ECC_ARB_STATS_EN
   logic [15:0] corr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt <= '0;
      end else if (state == S_WAIT && bus.codec_valid_out && op_q &&
                   bus.codec_error_corrected && corr_cnt != 16'hFFFF) begin
         corr_cnt <= corr_cnt + 16'd1;
      end
   end

   assign bus.corr_count = corr_cnt;
`else
   assign bus.corr_count = '0;
`endif
endmodule

// File: doc/repetition_ecc_arbiter.md
Name: repetition_ecc_arbiter

Overview:
- Shares one registered repetition-code codec (encode/decode, 1-cycle latency, valid_out strobe) among NUM_REQ requesters.
- Round-robin arbitration. Each transaction is sequenced through the codec, and the result is returned on a single response channel tagged with the requester index.
- Sits between client blocks (scrubber, memory wrapper) and the codec instance.

Parameters:
- DATA_WIDTH, 8, payload bits per word (must match codec).
- REPETITION_FACTOR, 3, copies per bit (odd, ≥3; must match codec).
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 15, max cycles waiting for codec_valid_out before aborting (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_op  in  NUM_REQ  per-requester op: 0 = encode, 1 = decode.
- req_payload  in  NUM_REQ*CW  flattened payloads, CW = DATA_WIDTH*REPETITION_FACTOR; requester i at [i*CW +: CW]; encode uses low DATA_WIDTH bits only.
- codec_encode_en  out  1  codec encode strobe.
- codec_decode_en  out  1  codec decode strobe.
- codec_data_in  out  DATA_WIDTH  codec data input.
- codec_codeword_in  out  CW  codec codeword input.
- codec_codeword_out  in  CW  codec encode result.
- codec_data_out  in  DATA_WIDTH  codec decode result.
- codec_error_corrected  in  1  codec corrected flag.
- codec_valid_out  in  1  codec result strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  clog2(NUM_REQ) (min 1)  requester index.
- rsp_op  out  1  echoed op.
- rsp_data  out  CW  encode: codeword; decode: zero-extended data.
- rsp_corrected  out  1  decode corrected an error.
- rsp_timeout  out  1  codec never responded.
- busy  out  1  state != IDLE.
- corr_count  out  16  corrected-error counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FSM = IDLE; rr pointer last_grant = NUM_REQ-1, so req 0 has first priority; latches cleared.
- IDLE:
  - If any req_valid, grant the first valid index searching upward from last_grant+1 modulo NUM_REQ.
  - Pulse req_ready[g] for exactly this cycle (the handshake completes here).
  - Latch op, payload and g; set last_grant = g; go to ISSUE.
  - No valid: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - Assert codec_encode_en or codec_decode_en per latched op (never both).
  - Drive codec_data_in = payload[DATA_WIDTH-1:0] and codec_codeword_in = payload; these stay driven from the latch in all states.
  - Clear wait counter; go to WAIT.
- WAIT:
  - On codec_valid_out, capture into rsp regs:
    - encode: rsp_data = codec_codeword_out, rsp_corrected = 0.
    - decode: rsp_data = {0, codec_data_out}, rsp_corrected = codec_error_corrected.
    - Set rsp_timeout = 0 and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT: rsp_data = 0, rsp_corrected = 0, rsp_timeout = 1; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_op and rsp_data are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid falls next cycle; go to IDLE.
  - Next arbitration starts the cycle after returning to IDLE, so there is no accept in the same cycle as the response handshake.
- Nominal latency (codec 1 cycle), request accept to rsp_valid: 3 cycles.
- Requests arriving while busy are not accepted; req_valid must be held by the requester, and its payload must stay stable until req_ready.
- codec_valid_out outside WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE; pending response discarded; rr pointer reset.
- NUM_REQ = 1: degenerates to a serial sequencer, id always 0.

Optional Feature:
- Macro: REPETITION_ECC_ARB_STATS_EN.
- Defined:
  - corr_count increments by 1 on each RESP entry with rsp_corrected = 1.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: corr_count tied to 0 and no counter logic is inferred.

Test Plan (DATA_WIDTH=8, REPETITION_FACTOR=3, NUM_REQ=2, codec model 1-cycle):
- Req0 encode 8'hA5, rsp_ready = 1 → req_ready = 2'b01; rsp_valid 3 cycles later; rsp_id = 0, rsp_data = 24'hE381C7, rsp_corrected = 0.
- Req1 decode 24'hE381C6 (bit 0 flipped) → rsp_id = 1, rsp_data = 24'h0000A5, rsp_corrected = 1, corr_count = 1 with macro, 0 without.
- Both req_valid held for 4 transactions → grants in order 0, 1, 0, 1; no back-to-back duplicate grant.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and all rsp fields stable; no req_ready pulses; IDLE re-entered the cycle after rsp_ready = 1.
- Codec model never asserts valid_out → rsp_timeout = 1 and rsp_data = 0, with rsp_valid asserted TIMEOUT (15) cycles after the ISSUE cycle.
- rst_n low during WAIT → all outputs 0 immediately; after release req0 is granted first even if req1 was last.
